// File: rtl/register_bank_if.sv
// Decode/writeback bus of the register bank: operand reads, result writes,
// destination reservations and the registered status outputs.
interface register_bank_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 2,
    parameter int unsigned AW     = $clog2(NREGS)
);
    logic [NREAD*AW-1:0]    rd_addr;
    logic [NREAD*XLEN-1:0]  rd_data;
    logic [NREAD-1:0]       rd_busy;
    logic [NWRITE-1:0]      wr_en;
    logic [NWRITE*AW-1:0]   wr_addr;
    logic [NWRITE*XLEN-1:0] wr_data;
    logic                   rsv_en;
    logic [AW-1:0]          rsv_addr;
    logic [NREGS-1:0]       busy_vec;
    logic                   zero_write;
    logic                   wr_collide;

    // Pipeline side: drives addresses, write data and reservations.
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, busy_vec, zero_write, wr_collide
    );

    // Register bank side.
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, busy_vec, zero_write, wr_collide
    );
endinterface

// File: rtl/register_bank.sv
// Multi-port register file with a pending-write scoreboard and optional
// same-cycle write-to-read forwarding.
module register_bank #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 16,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned NWRITE   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic            i_clock,
    input  logic            i_reset,
    register_bank_if.slave  io_bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic             r_zero_write;
    logic             r_wr_collide;

    logic [NREGS-1:0] w_wr_hit;
    logic [XLEN-1:0]  w_wr_data [NREGS];
    logic             w_collide;
    logic             w_zero_hit;
    logic [NREGS-1:0] w_busy_d;
    logic [NREAD*XLEN-1:0] w_rd_data;
    logic [NREAD-1:0]      w_rd_busy;

    // Per-register write resolution; ascending scan lets the highest port win.
    always_comb begin
        w_wr_hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_wr_data[r] = '0;
        end
        for (int j = 0; j < NWRITE; j++) begin
            if (io_bus.wr_en[j]) begin
                w_wr_hit[io_bus.wr_addr[j*AW +: AW]]  = 1'b1;
                w_wr_data[io_bus.wr_addr[j*AW +: AW]] = io_bus.wr_data[j*XLEN +: XLEN];
            end
        end
    end

    // Detect shared write addresses and writes aimed at the hardwired zero register.
    always_comb begin
        w_collide  = 1'b0;
        w_zero_hit = 1'b0;
        for (int j = 0; j < NWRITE; j++) begin
            if (io_bus.wr_en[j]) begin
                if ((ZERO_REG != 0) && (io_bus.wr_addr[j*AW +: AW] == '0)) begin
                    w_zero_hit = 1'b1;
                end
                for (int k = j + 1; k < NWRITE; k++) begin
                    if (io_bus.wr_en[k] &&
                        (io_bus.wr_addr[k*AW +: AW] == io_bus.wr_addr[j*AW +: AW])) begin
                        w_collide = 1'b1;
                    end
                end
            end
        end
    end

    // Scoreboard next state: a new reservation beats a same-cycle release.
    always_comb begin
        w_busy_d = r_busy;
        for (int r = 0; r < NREGS; r++) begin
            if (io_bus.rsv_en && (io_bus.rsv_addr == AW'(r)) &&
                !((ZERO_REG != 0) && (r == 0))) begin
                w_busy_d[r] = 1'b1;
            end else if (w_wr_hit[r]) begin
                w_busy_d[r] = 1'b0;
            end
        end
    end

    // State update; reset discards any write or reservation in the same cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
            r_busy       <= '0;
            r_zero_write <= 1'b0;
            r_wr_collide <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_wr_hit[r] && !((ZERO_REG != 0) && (r == 0))) begin
                    r_regs[r] <= w_wr_data[r];
                end
            end
            r_busy       <= w_busy_d;
            r_zero_write <= w_zero_hit;
            r_wr_collide <= w_collide;
        end
    end

    // Combinational read ports with forwarding and zero-register override.
    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if ((ZERO_REG != 0) && (io_bus.rd_addr[i*AW +: AW] == '0)) begin
                w_rd_data[i*XLEN +: XLEN] = '0;
                w_rd_busy[i]              = 1'b0;
            end else if ((BYPASS != 0) && w_wr_hit[io_bus.rd_addr[i*AW +: AW]]) begin
                w_rd_data[i*XLEN +: XLEN] = w_wr_data[io_bus.rd_addr[i*AW +: AW]];
                w_rd_busy[i]              = 1'b0;
            end else begin
                w_rd_data[i*XLEN +: XLEN] = r_regs[io_bus.rd_addr[i*AW +: AW]];
                w_rd_busy[i]              = r_busy[io_bus.rd_addr[i*AW +: AW]];
            end
        end
    end

    assign io_bus.rd_data    = w_rd_data;
    assign io_bus.rd_busy    = w_rd_busy;
    assign io_bus.busy_vec   = r_busy;
    assign io_bus.zero_write = r_zero_write;
    assign io_bus.wr_collide = r_wr_collide;
endmodule

// File: tb/tb_register_bank.sv
// Randomized bench for register_bank: two instances (forwarding + zero register,
// and plain storage without either) share stimulus and are compared to a model.
module tb_register_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    register_bank_if #(.XLEN(32), .NREGS(16), .NREAD(2), .NWRITE(2)) bus_a ();
    register_bank_if #(.XLEN(32), .NREGS(16), .NREAD(2), .NWRITE(2)) bus_b ();

    register_bank #(
        .XLEN(32), .NREGS(16), .NREAD(2), .NWRITE(2), .BYPASS(1), .ZERO_REG(1)
    ) u_dut_a (
        .i_clock (clk),
        .i_reset (rst),
        .io_bus  (bus_a)
    );

    register_bank #(
        .XLEN(32), .NREGS(16), .NREAD(2), .NWRITE(2), .BYPASS(0), .ZERO_REG(0)
    ) u_dut_b (
        .i_clock (clk),
        .i_reset (rst),
        .io_bus  (bus_b)
    );

    // Stimulus for the current cycle.
    logic [1:0]  en;
    logic [3:0]  wa [2];
    logic [31:0] wd [2];
    logic        rsv;
    logic [3:0]  ra;
    logic [3:0]  rda [2];

    // Reference state; index 0 = forwarding/zero config, 1 = plain config.
    logic [31:0] m_mem  [2][16];
    bit          m_busy [2][16];
    bit          m_zw   [2];
    bit          m_col  [2];

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit cfg_byp(input int c);
        return c == 0;
    endfunction

    function automatic bit cfg_zr(input int c);
        return c == 0;
    endfunction

    // Expected read result for address a in config c under the current stimulus.
    task automatic model_read(input int c, input logic [3:0] a,
                              output logic [31:0] d, output bit b);
        int w;
        w = -1;
        for (int j = 0; j < 2; j++) begin
            if (en[j] && wa[j] == a) w = j;
        end
        if (cfg_zr(c) && a == 0) begin
            d = 0; b = 0;
        end else if (cfg_byp(c) && w >= 0) begin
            d = wd[w]; b = 0;
        end else begin
            d = m_mem[c][a]; b = m_busy[c][a];
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 16; r++) begin
                m_mem[c][r]  = 0;
                m_busy[c][r] = 0;
            end
            m_zw[c]  = 0;
            m_col[c] = 0;
        end
    endtask

    task automatic model_update();
        bit written;
        if (rst) begin
            model_clear();
            return;
        end
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 16; r++) begin
                written = 0;
                for (int j = 0; j < 2; j++) begin
                    if (en[j] && wa[j] == r) written = 1;
                end
                if (rsv && ra == r && !(cfg_zr(c) && r == 0)) m_busy[c][r] = 1;
                else if (written) m_busy[c][r] = 0;
            end
            m_zw[c] = 0;
            for (int j = 0; j < 2; j++) begin
                if (en[j]) begin
                    if (cfg_zr(c) && wa[j] == 0) m_zw[c] = 1;
                    else m_mem[c][wa[j]] = wd[j];
                end
            end
            m_col[c] = en[0] && en[1] && (wa[0] == wa[1]);
        end
    endtask

    task automatic drive();
        bus_a.wr_en    = en;            bus_b.wr_en    = en;
        bus_a.wr_addr  = {wa[1], wa[0]}; bus_b.wr_addr  = {wa[1], wa[0]};
        bus_a.wr_data  = {wd[1], wd[0]}; bus_b.wr_data  = {wd[1], wd[0]};
        bus_a.rsv_en   = rsv;           bus_b.rsv_en   = rsv;
        bus_a.rsv_addr = ra;            bus_b.rsv_addr = ra;
        bus_a.rd_addr  = {rda[1], rda[0]};
        bus_b.rd_addr  = {rda[1], rda[0]};
    endtask

    task automatic set_idle();
        en = 0; wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
        rsv = 0; ra = 0; rda[0] = 0; rda[1] = 0; rst = 0;
    endtask

    // One clock cycle: check reads, advance the model, check registered outputs.
    task automatic step();
        logic [31:0] ed, gd;
        bit          eb;
        logic        gb;
        logic [15:0] ev, gv;
        drive();
        #1;
        if (!rst) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < 2; i++) begin
                    model_read(c, rda[i], ed, eb);
                    gd = (c == 0) ? bus_a.rd_data[i*32 +: 32] : bus_b.rd_data[i*32 +: 32];
                    gb = (c == 0) ? bus_a.rd_busy[i] : bus_b.rd_busy[i];
                    check_eq($sformatf("rd_data%0d_cfg%0d_a%0d", i, c, rda[i]), 64'(gd), 64'(ed));
                    check_eq($sformatf("rd_busy%0d_cfg%0d_a%0d", i, c, rda[i]), 64'(gb), 64'(eb));
                end
            end
        end
        model_update();
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 16; r++) ev[r] = m_busy[c][r];
            gv = (c == 0) ? bus_a.busy_vec : bus_b.busy_vec;
            check_eq($sformatf("busy_vec_cfg%0d", c), 64'(gv), 64'(ev));
            check_eq($sformatf("zero_write_cfg%0d", c),
                     64'((c == 0) ? bus_a.zero_write : bus_b.zero_write), 64'(m_zw[c]));
            check_eq($sformatf("wr_collide_cfg%0d", c),
                     64'((c == 0) ? bus_a.wr_collide : bus_b.wr_collide), 64'(m_col[c]));
        end
    endtask

    initial begin
        set_idle();
        rst = 1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        rst = 0;

        // Every register reads zero after reset.
        for (int p = 0; p < 8; p++) begin
            set_idle(); rda[0] = 4'(2 * p); rda[1] = 4'(2 * p + 1); step();
        end

        // Write 0xDEADBEEF to r5 via port 0 while reading it, then read again.
        set_idle(); en = 2'b01; wa[0] = 5; wd[0] = 32'hDEADBEEF; rda[0] = 5; step();
        set_idle(); rda[0] = 5; step();

        // Both ports write r3; port 1 must win, collision pulses once.
        set_idle(); en = 2'b11; wa[0] = 3; wd[0] = 32'h11; wa[1] = 3; wd[1] = 32'h22;
        rda[0] = 3; step();
        set_idle(); rda[0] = 3; step();

        // Writes and reservations of r0.
        set_idle(); en = 2'b01; wa[0] = 0; wd[0] = 32'h55; rda[0] = 0; step();
        set_idle(); rsv = 1; ra = 0; rda[0] = 0; step();
        set_idle(); rda[0] = 0; step();

        // Scoreboard on r7: reserve, release by write, reserve with write.
        set_idle(); rsv = 1; ra = 7; rda[0] = 7; step();
        set_idle(); rda[0] = 7; step();
        set_idle(); en = 2'b10; wa[1] = 7; wd[1] = 32'h99; rda[0] = 7; rda[1] = 7; step();
        set_idle(); rda[0] = 7; step();
        set_idle(); rsv = 1; ra = 7; en = 2'b01; wa[0] = 7; wd[0] = 32'h77; rda[0] = 7; step();
        set_idle(); rda[0] = 7; step();

        // Reserve r2 and r4, then reset with a write to r9 in the reset cycle.
        set_idle(); rsv = 1; ra = 2; step();
        set_idle(); rsv = 1; ra = 4; rda[0] = 2; step();
        set_idle(); rst = 1; en = 2'b01; wa[0] = 9; wd[0] = 32'hCAFE; rsv = 1; ra = 6; step();
        set_idle(); rda[0] = 9; rda[1] = 2; step();
        set_idle(); rda[0] = 4; rda[1] = 5; step();

        // Randomized traffic with addresses folded into a small range for collisions.
        for (int n = 0; n < 600; n++) begin
            rst    = ($urandom_range(63) == 0);
            en     = 2'($urandom_range(3));
            wa[0]  = 4'($urandom_range(7));
            wa[1]  = 4'($urandom_range(7));
            wd[0]  = $urandom;
            wd[1]  = $urandom;
            rsv    = 1'($urandom_range(1));
            ra     = 4'($urandom_range(7));
            rda[0] = ($urandom_range(1) == 1) ? wa[0] : 4'($urandom_range(15));
            rda[1] = ($urandom_range(1) == 1) ? wa[1] : 4'($urandom_range(15));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
